// File: rtl/pn_token_feeder_if.sv
// Token-feeder bus: host token writes, the PN input/output beats and host result beats.
// The master modport is the host/PN side and the slave modport is the feeder.
interface pn_token_feeder_if;
  logic               wr_valid;
  logic               wr_ready;
  logic               wr_operator;
  logic [2:0]         wr_data;
  logic               wr_last;
  logic [1:0]         wr_mode;
  logic [1:0]         pn_mode;
  logic               pn_operator;
  logic [2:0]         pn_in;
  logic               pn_in_valid;
  logic               pn_out_valid;
  logic signed [31:0] pn_out;
  logic               res_valid;
  logic signed [31:0] res_data;
  logic [1:0]         res_idx;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output wr_valid, wr_operator, wr_data, wr_last, wr_mode, pn_out_valid, pn_out,
    input  wr_ready, pn_mode, pn_operator, pn_in, pn_in_valid,
    input  res_valid, res_data, res_idx, busy, done, err
  );

  modport slave (
    input  wr_valid, wr_operator, wr_data, wr_last, wr_mode, pn_out_valid, pn_out,
    output wr_ready, pn_mode, pn_operator, pn_in, pn_in_valid,
    output res_valid, res_data, res_idx, busy, done, err
  );
endinterface

// File: rtl/pn_token_feeder.sv
// Buffers one host expression, replays it to the PN evaluator as one contiguous burst,
// then forwards PN result beats to the host with done/err completion pulses.
module pn_token_feeder #(
  parameter int MAX_TOK = 12,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  pn_token_feeder_if.slave bus
);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {LOAD, CHECK, SEND, WAIT} state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] send_idx;
  logic [1:0]       mode_q;
  logic [2:0]       exp_q;
  logic [2:0]       exp_next;
  logic [2:0]       beat;
  logic [TO_W-1:0]  to_cnt;
  logic             wr_accept;
  logic             tok_op   [MAX_TOK];
  logic [2:0]       tok_data [MAX_TOK];

  assign wr_accept = bus.wr_valid && bus.wr_ready;

  // Prefix modes yield one result per three tokens; postfix modes always yield one.
  assign exp_next = (mode_q < 2'd2) ? 3'(cnt / CNT_W'(3)) : 3'd1;

  // NOTE: the token buffer is deliberately not reset; cnt alone marks which entries are live.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      tok_op[cnt]   <= bus.wr_operator;
      tok_data[cnt] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= LOAD;
      cnt             <= '0;
      send_idx        <= '0;
      mode_q          <= '0;
      exp_q           <= '0;
      beat            <= '0;
      to_cnt          <= '0;
      bus.wr_ready    <= 1'b1;
      bus.pn_mode     <= '0;
      bus.pn_operator <= 1'b0;
      bus.pn_in       <= '0;
      bus.pn_in_valid <= 1'b0;
      bus.res_valid   <= 1'b0;
      bus.res_data    <= '0;
      bus.res_idx     <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.err         <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults here turn done/err/res_valid into single-cycle pulses.
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.res_valid <= 1'b0;
      case (state)
        LOAD: begin
          if (wr_accept) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == '0) mode_q <= bus.wr_mode;
            if (bus.wr_last || cnt == CNT_W'(MAX_TOK - 1)) begin
              state        <= CHECK;
              bus.wr_ready <= 1'b0;
              bus.busy     <= 1'b1;
            end
          end
        end
        CHECK: begin
          if (exp_next == 3'd0) begin
            bus.err      <= 1'b1;
            cnt          <= '0;
            state        <= LOAD;
            bus.wr_ready <= 1'b1;
            bus.busy     <= 1'b0;
          end else begin
            // Beat 0 goes out on this edge so the burst is exactly cnt cycles long.
            exp_q           <= exp_next;
            state           <= SEND;
            bus.pn_in_valid <= 1'b1;
            bus.pn_mode     <= mode_q;
            bus.pn_operator <= tok_op[0];
            bus.pn_in       <= tok_data[0];
            send_idx        <= CNT_W'(1);
          end
        end
        SEND: begin
          bus.pn_mode <= '0;
          if (send_idx < cnt) begin
            bus.pn_operator <= tok_op[send_idx];
            bus.pn_in       <= tok_data[send_idx];
            send_idx        <= send_idx + CNT_W'(1);
          end else begin
            bus.pn_in_valid <= 1'b0;
            bus.pn_operator <= 1'b0;
            bus.pn_in       <= '0;
            beat            <= '0;
            to_cnt          <= '0;
            state           <= WAIT;
          end
        end
        WAIT: begin
          // A beat arriving on the timeout cycle takes priority over the timeout.
          if (bus.pn_out_valid) begin
            bus.res_valid <= 1'b1;
            bus.res_data  <= bus.pn_out;
            bus.res_idx   <= beat[1:0];
            beat          <= beat + 3'd1;
            to_cnt        <= '0;
            if (beat == exp_q - 3'd1) begin
              bus.done     <= 1'b1;
              cnt          <= '0;
              state        <= LOAD;
              bus.wr_ready <= 1'b1;
              bus.busy     <= 1'b0;
            end
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            bus.err      <= 1'b1;
            cnt          <= '0;
            state        <= LOAD;
            bus.wr_ready <= 1'b1;
            bus.busy     <= 1'b0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_pn_token_feeder.sv
// Bench for pn_token_feeder: directed scenarios plus randomized expressions checked
// against a token-list model of burst contents, result-beat count and completion status.
module tb_pn_token_feeder;
  localparam int MAX_TOK = 12;
  localparam int TIMEOUT = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pn_token_feeder_if bus ();

  pn_token_feeder #(.MAX_TOK(MAX_TOK), .TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model inputs: expression tokens and the values the PN stand-in will return.
  logic               tk_op   [MAX_TOK];
  logic [2:0]         tk_dat  [MAX_TOK];
  logic signed [31:0] pn_vals [4];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic write_tokens(input logic [1:0] mode, input int n, input bit use_last,
                              input bit hold_extra);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.wr_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL write wr_ready tok %0d: got %b want 1", i, bus.wr_ready);
      end
      bus.wr_valid    = 1'b1;
      bus.wr_operator = tk_op[i];
      bus.wr_data     = tk_dat[i];
      bus.wr_last     = use_last && (i == n - 1);
      bus.wr_mode     = (i == 0) ? mode : ~mode;
    end
    @(negedge clk);
    if (hold_extra) begin
      bus.wr_operator = 1'b1;
      bus.wr_data     = 3'd7;
      bus.wr_last     = 1'b1;
    end else begin
      bus.wr_valid = 1'b0;
      bus.wr_last  = 1'b0;
    end
  endtask

  // plan: 0 = PN answers every beat, 1 = PN silent, 2 = first beat on the last legal cycle.
  task automatic run_expr(input string name, input logic [1:0] mode, input int n,
                          input bit use_last, input bit hold_extra, input int plan,
                          input int gap_max);
    int nb, seen, w, early, spurious, g;
    nb = (mode < 2'd2) ? n / 3 : 1;
    write_tokens(mode, n, use_last, hold_extra);
    vectors++;
    if (bus.wr_ready !== 1'b0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s post-accept: got wr_ready=%b busy=%b want 0/1", name, bus.wr_ready, bus.busy);
    end
    if (nb == 0) begin
      @(negedge clk);
      vectors++;
      if (bus.err !== 1'b1 || bus.done !== 1'b0 || bus.pn_in_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL %s reject pulse: got err=%b done=%b in_valid=%b want 1/0/0",
                 name, bus.err, bus.done, bus.pn_in_valid);
      end
      @(negedge clk);
      vectors++;
      if (bus.wr_ready !== 1'b1 || bus.err !== 1'b0 || bus.pn_in_valid !== 1'b0 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL %s after reject: got wr_ready=%b err=%b in_valid=%b busy=%b want 1/0/0/0",
                 name, bus.wr_ready, bus.err, bus.pn_in_valid, bus.busy);
      end
      return;
    end
    w = 0;
    while (bus.pn_in_valid !== 1'b1 && w < 8) begin
      @(negedge clk);
      w++;
    end
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    vectors++;
    if (bus.pn_in_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s burst start: got in_valid=%b want 1 within 8 cycles", name, bus.pn_in_valid);
    end
    seen = 0;
    while (bus.pn_in_valid === 1'b1 && seen < MAX_TOK + 2) begin
      if (seen < n) begin
        vectors++;
        if (bus.pn_operator !== tk_op[seen] || bus.pn_in !== tk_dat[seen] ||
            bus.pn_mode !== ((seen == 0) ? mode : 2'd0)) begin
          miscompares++;
          $display("FAIL %s beat %0d: got op=%b in=%0d mode=%0d want op=%b in=%0d mode=%0d",
                   name, seen, bus.pn_operator, bus.pn_in, bus.pn_mode, tk_op[seen], tk_dat[seen],
                   (seen == 0) ? mode : 2'd0);
        end
      end
      seen++;
      @(negedge clk);
    end
    vectors++;
    if (seen != n) begin
      miscompares++;
      $display("FAIL %s burst length: got %0d want %0d", name, seen, n);
    end
    vectors++;
    if (bus.pn_operator !== 1'b0 || bus.pn_in !== 3'd0 || bus.pn_mode !== 2'd0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s idle bus: got op=%b in=%0d mode=%0d busy=%b want 0/0/0/1",
               name, bus.pn_operator, bus.pn_in, bus.pn_mode, bus.busy);
    end
    if (plan == 1) begin
      early = 0;
      for (int c = 1; c < TIMEOUT; c++) begin
        @(negedge clk);
        if (bus.err === 1'b1 || bus.res_valid === 1'b1) early++;
      end
      vectors++;
      if (early != 0) begin
        miscompares++;
        $display("FAIL %s early timeout: got %0d pulses want 0", name, early);
      end
      @(negedge clk);
      vectors++;
      if (bus.err !== 1'b1 || bus.done !== 1'b0 || bus.res_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL %s timeout pulse: got err=%b done=%b res_valid=%b want 1/0/0",
                 name, bus.err, bus.done, bus.res_valid);
      end
      @(negedge clk);
      vectors++;
      if (bus.wr_ready !== 1'b1 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
        miscompares++;
        $display("FAIL %s after timeout: got wr_ready=%b busy=%b err=%b want 1/0/0",
                 name, bus.wr_ready, bus.busy, bus.err);
      end
      return;
    end
    spurious = 0;
    for (int j = 0; j < nb; j++) begin
      g = (plan == 2 && j == 0) ? TIMEOUT - 1 : int'($urandom_range(gap_max, 0));
      bus.pn_out_valid = 1'b0;
      repeat (g) begin
        @(negedge clk);
        if (bus.err === 1'b1 || bus.res_valid === 1'b1 || bus.done === 1'b1) spurious++;
      end
      bus.pn_out_valid = 1'b1;
      bus.pn_out       = pn_vals[j];
      @(negedge clk);
      bus.pn_out_valid = 1'b0;
      vectors++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== pn_vals[j] || bus.res_idx !== 2'(j) ||
          bus.done !== (j == nb - 1) || bus.err !== 1'b0) begin
        miscompares++;
        $display("FAIL %s result %0d: got valid=%b data=%0d idx=%0d done=%b err=%b want 1/%0d/%0d/%b/0",
                 name, j, bus.res_valid, bus.res_data, bus.res_idx, bus.done, bus.err,
                 pn_vals[j], j, (j == nb - 1));
      end
    end
    vectors++;
    if (spurious != 0) begin
      miscompares++;
      $display("FAIL %s idle outputs in WAIT: got %0d pulses want 0", name, spurious);
    end
    bus.pn_out_valid = 1'b1;
    bus.pn_out       = 32'sh7fff_0000;
    @(negedge clk);
    bus.pn_out_valid = 1'b0;
    vectors++;
    if (bus.res_valid !== 1'b0 || bus.done !== 1'b0 || bus.wr_ready !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s after done: got res_valid=%b done=%b wr_ready=%b busy=%b want 0/0/1/0",
               name, bus.res_valid, bus.done, bus.wr_ready, bus.busy);
    end
  endtask

  task automatic test_reset();
    bus.wr_valid = 1'b0; bus.wr_operator = 1'b0; bus.wr_data = '0; bus.wr_last = 1'b0;
    bus.wr_mode = '0; bus.pn_out_valid = 1'b0; bus.pn_out = '0;
    rst_n = 1'b0;
    #12;
    vectors++;
    if (bus.wr_ready !== 1'b1 || bus.pn_in_valid !== 1'b0 || bus.pn_mode !== 2'd0 ||
        bus.res_valid !== 1'b0 || bus.res_data !== 32'sd0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset state: got wr_ready=%b in_valid=%b busy=%b done=%b err=%b res_valid=%b",
               bus.wr_ready, bus.pn_in_valid, bus.busy, bus.done, bus.err, bus.res_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mode0_two_results();
    tk_op  = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    tk_dat = '{0, 3, 4, 2, 2, 5, 0, 0, 0, 0, 0, 0};
    pn_vals = '{32'sd10, 32'sd7, 32'sd0, 32'sd0};
    run_expr("mode0", 2'd0, 6, 1'b1, 1'b0, 0, 2);
  endtask

  task automatic test_mode3_single();
    tk_op  = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    tk_dat = '{2, 3, 0, 4, 2, 0, 0, 0, 0, 0, 0, 0};
    pn_vals = '{32'sd20, 32'sd0, 32'sd0, 32'sd0};
    run_expr("mode3", 2'd3, 5, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic test_short_reject();
    tk_dat[0] = 3'd1; tk_dat[1] = 3'd2; tk_op[0] = 1'b0; tk_op[1] = 1'b0;
    run_expr("short", 2'd1, 2, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic test_max_tokens();
    for (int i = 0; i < MAX_TOK; i++) begin
      tk_op[i]  = 1'($urandom_range(1, 0));
      tk_dat[i] = 3'($urandom_range(7, 0));
    end
    for (int k = 0; k < 4; k++) pn_vals[k] = $urandom;
    run_expr("max_tok", 2'd0, MAX_TOK, 1'b0, 1'b1, 0, 3);
  endtask

  task automatic test_timeout();
    tk_op  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tk_dat = '{6, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_expr("timeout", 2'd2, 3, 1'b1, 1'b0, 1, 0);
    pn_vals = '{-32'sd5, 32'sd0, 32'sd0, 32'sd0};
    run_expr("late_beat", 2'd2, 3, 1'b1, 1'b0, 2, 0);
  endtask

  task automatic test_reset_mid_send();
    int w;
    for (int i = 0; i < 8; i++) begin
      tk_op[i]  = 1'(i % 2);
      tk_dat[i] = 3'(i);
    end
    write_tokens(2'd2, 8, 1'b1, 1'b0);
    w = 0;
    while (bus.pn_in_valid !== 1'b1 && w < 8) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.pn_in_valid !== 1'b1 || bus.pn_in !== 3'd3) begin
      miscompares++;
      $display("FAIL midreset precondition: got in_valid=%b in=%0d want 1/3", bus.pn_in_valid, bus.pn_in);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.pn_in_valid !== 1'b0 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset outputs: got in_valid=%b busy=%b res_valid=%b wr_ready=%b want 0/0/0/1",
               bus.pn_in_valid, bus.busy, bus.res_valid, bus.wr_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tk_op  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    tk_dat = '{7, 6, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    pn_vals = '{32'sd99, 32'sd0, 32'sd0, 32'sd0};
    run_expr("post_reset", 2'd3, 4, 1'b1, 1'b0, 0, 1);
  endtask

  task automatic test_random();
    int n;
    logic [1:0] mode;
    bit use_last;
    for (int it = 0; it < 25; it++) begin
      mode = 2'($urandom_range(3, 0));
      n    = int'($urandom_range(MAX_TOK, 1));
      use_last = (n < MAX_TOK) ? 1'b1 : 1'($urandom_range(1, 0));
      for (int i = 0; i < MAX_TOK; i++) begin
        tk_op[i]  = 1'($urandom_range(1, 0));
        tk_dat[i] = 3'($urandom_range(7, 0));
      end
      for (int k = 0; k < 4; k++) pn_vals[k] = $urandom;
      run_expr("random", mode, n, use_last, 1'b0, 0, 4);
    end
  endtask

  initial begin
    test_reset();
    test_mode0_two_results();
    test_mode3_single();
    test_short_reject();
    test_max_tokens();
    test_timeout();
    test_reset_mid_send();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
